pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline buffer; successor to the fixed-field ID/EX-style register.
- Carries an opaque data payload plus a control vector between two pipeline stages, using a valid/ready handshake and a 2-entry skid so backpressure does not create a combinational ready path.
- Supports flush (squash everything), hazard bubble insertion (NOP beat with control cleared) and a saturating bubble counter for perf monitoring.
- Instantiated between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 64, payload width (PC, operands, immediates, instruction).
- CTRL_W, 16, control-bit vector width; all bits are cleared on bubble/flush.
- NOP_DATA, {DATA_W{1'b0}} | 16'h0800, payload value written on bubble and reset (low 16 bits = NOP encoding).
- BUBBLE_VALID, 1, 1 = a bubble is emitted as a valid NOP beat; 0 = a bubble emits nothing.
- CNT_W, 16, bubble counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  buffer can accept a beat
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bits
- flush  in  1  squash all held and incoming beats
- bubble  in  1  hazard stall: block upstream, optionally inject NOP
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts beat
- out_data  out  DATA_W  head payload
- out_ctrl  out  CTRL_W  head control
- occupancy  out  2  entries held (0..2)
- bubble_cnt  out  CNT_W  bubbles injected, saturating

Behaviour:
- Storage: main entry (head, drives out_*) and skid entry. Each entry holds valid, data and ctrl.
- Reset (rst=0, async):
  - both entries invalid; out_valid=0, out_data=NOP_DATA, out_ctrl=0
  - occupancy=0, bubble_cnt=0, in_ready=1 once rst releases
- in_ready = ~skid.valid & ~bubble. The skid term is registered; bubble is the only combinational term.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Latency from push to out_valid is 1 cycle when the buffer is empty.
- Priority: flush > bubble > normal.
- Flush (cycle N):
  - both entries invalidated at the N edge; out_valid=0 in N+1
  - any push in cycle N is discarded; a pop in cycle N still completes downstream
  - ctrl is cleared, data is set to NOP_DATA
  - in_ready=1 in N+1 (unless bubble)
- Normal transitions, by occupancy:
  - occ 0, push: beat goes to main.
  - occ 1, push without pop: beat goes to skid; in_ready=0 next cycle.
  - occ 1, push with pop: beat goes to main.
  - occ 1, pop without push: main becomes invalid.
  - occ 2, pop: skid moves to main, skid becomes invalid; in_ready=1 next cycle. A push is impossible at occ 2.
- Bubble (flush=0):
  - No push occurs.
  - If BUBBLE_VALID=1 and main is empty at the end of the cycle (occ 0, or occ 1 with pop), main is loaded with {valid=1, data=NOP_DATA, ctrl=0}, and bubble_cnt increments, saturating at all-ones.
  - Otherwise held entries drain normally and no counter change occurs.
- Held beats are never modified while out_ready=0; out_data and out_ctrl are stable while out_valid & ~out_ready.
- Ordering: beats leave in push order; no duplication, no loss except on flush.

Decomposition:
- Package pipe_pkg holds:
  - NOP_INSN = 16'h0800
  - default widths
  - a struct/typedef for the entry {valid, data, ctrl}
- One sub-module, pipe_entry: an enable/clear register slice with asynchronous active-low reset to {0, NOP_DATA, 0}. It is instantiated twice (main, skid).
- Handshake and state logic live in the top module.

Test Plan:
- Reset then stream 8 beats with out_ready=1 and in_valid=1 → each beat appears 1 cycle later, in order; occupancy stays 1; in_ready stays 1.
- Push A,B with out_ready=0 → occupancy=2, in_ready=0, out_data=A stable; raise out_ready → A then B drain; in_ready=1 the cycle after A pops.
- At occupancy 2, assert flush together with in_valid=1 (data C) → next cycle out_valid=0, occupancy=0, C never appears, out_ctrl=0.
- bubble=1 for 3 cycles on an empty buffer (BUBBLE_VALID=1, out_ready=1) → in_ready=0, 3 NOP beats out (data low 16 = 0x0800, ctrl=0), bubble_cnt=3.
- CNT_W=2, 5 consecutive bubbles → bubble_cnt saturates at 3.
- Assert rst=0 asynchronously mid-stream at occupancy 2 → outputs return to reset values immediately without waiting for a clock edge; no beat is emitted after rst rises until a new push.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants, default widths and the entry type for pipe_stage_buf.
package pipe_pkg;

   // Low 16 bits of the payload when a stage carries no instruction.
   localparam logic [15:0] NOP_INSN = 16'h0800;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_CTRL_W = 16;
   localparam int DEF_CNT_W  = 16;

   // One buffer entry at the default widths.
   typedef struct packed {
      logic                  valid;
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_CTRL_W-1:0] ctrl;
   } entry_t;

   // Number of valid entries held, given the main and skid valid bits.
   function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
      return {1'b0, main_v} + {1'b0, skid_v};
   endfunction

endpackage

// File: rtl/pipe_entry.sv
// Register slice holding one {valid, data, ctrl} entry, with load enable and
// synchronous clear back to the empty NOP value.
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                CTRL_W   = DEF_CTRL_W,
   parameter logic [DATA_W-1:0] NOP_DATA = DATA_W'(NOP_INSN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic              d_valid,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              q_valid,
   output logic [DATA_W-1:0] q_data,
   output logic [CTRL_W-1:0] q_ctrl
);

   // Clear wins over load; reset and clear both leave an empty NOP entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_valid <= 1'b0;
         q_data  <= NOP_DATA;
         q_ctrl  <= '0;
      end else if (clr) begin
         q_valid <= 1'b0;
         q_data  <= NOP_DATA;
         q_ctrl  <= '0;
      end else if (en) begin
         q_valid <= d_valid;
         q_data  <= d_data;
         q_ctrl  <= d_ctrl;
      end
   end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: main entry drives the outputs, skid entry
// absorbs one beat of backpressure so in_ready never depends on out_ready.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. The sender holds valid/data/ctrl stable until the transfer; ready may
// change freely while valid is low. out_* are stable while out_valid & ~out_ready.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int                DATA_W       = DEF_DATA_W,
   parameter int                CTRL_W       = DEF_CTRL_W,
   parameter logic [DATA_W-1:0] NOP_DATA     = DATA_W'(NOP_INSN),
   parameter bit                BUBBLE_VALID = 1'b1,
   parameter int                CNT_W        = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   input  logic              bubble,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  bubble_cnt
);

   logic              main_v, skid_v;
   logic [DATA_W-1:0] main_data, skid_data, main_d_data;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
   logic              main_en, main_clr, skid_en, skid_clr;
   logic              push, pop, inject;

   // bubble is the only combinational term in in_ready; skid_v is registered.
   assign in_ready  = ~skid_v & ~bubble;
   assign push      = in_valid & in_ready;
   assign pop       = main_v & out_ready;
   assign out_valid = main_v;
   assign out_data  = main_data;
   assign out_ctrl  = main_ctrl;
   assign occupancy = occ_count(main_v, skid_v);

   // A NOP beat is injected only if main would otherwise be empty after this edge.
   assign inject = BUBBLE_VALID && bubble && !flush && (!main_v || (pop && !skid_v));

   // Entry update control: flush > bubble injection > normal push/pop movement.
   always_comb begin
      main_en     = 1'b0;
      main_clr    = 1'b0;
      main_d_data = in_data;
      main_d_ctrl = in_ctrl;
      skid_en     = 1'b0;
      skid_clr    = 1'b0;
      if (flush) begin
         main_clr = 1'b1;
         skid_clr = 1'b1;
      end else if (inject) begin
         main_en     = 1'b1;
         main_d_data = NOP_DATA;
         main_d_ctrl = '0;
      end else if (pop) begin
         if (skid_v) begin
            main_en     = 1'b1;
            main_d_data = skid_data;
            main_d_ctrl = skid_ctrl;
            skid_clr    = 1'b1;
         end else if (push) begin
            main_en = 1'b1;
         end else begin
            main_clr = 1'b1;
         end
      end else if (push) begin
         if (main_v) skid_en = 1'b1;
         else        main_en = 1'b1;
      end
   end

   // Saturating count of injected NOP beats.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                bubble_cnt <= '0;
      else if (inject && (bubble_cnt != '1))   bubble_cnt <= bubble_cnt + CNT_W'(1);
   end

   pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_DATA(NOP_DATA)) u_main (
      .clk     (clk),
      .rst     (rst),
      .en      (main_en),
      .clr     (main_clr),
      .d_valid (1'b1),
      .d_data  (main_d_data),
      .d_ctrl  (main_d_ctrl),
      .q_valid (main_v),
      .q_data  (main_data),
      .q_ctrl  (main_ctrl)
   );

   pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_DATA(NOP_DATA)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .en      (skid_en),
      .clr     (skid_clr),
      .d_valid (1'b1),
      .d_data  (in_data),
      .d_ctrl  (in_ctrl),
      .q_valid (skid_v),
      .q_data  (skid_data),
      .q_ctrl  (skid_ctrl)
   );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed stimulus, expected beats queued at issue
// time and compared by a monitor whenever the DUT hands a beat downstream.
module tb_pipe_stage_buf;

   localparam logic [63:0] NOP64 = 64'h0000_0000_0000_0800;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] in_data  = '0;
   logic [15:0] in_ctrl  = '0;
   logic        flush    = 1'b0;
   logic        bubble   = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid;
   logic [63:0] out_data;
   logic [15:0] out_ctrl;
   logic [1:0]  occupancy;
   logic [15:0] bubble_cnt;

   logic        s_in_ready, s_out_valid;
   logic [63:0] s_out_data;
   logic [15:0] s_out_ctrl;
   logic [1:0]  s_occupancy;
   logic [1:0]  s_bubble_cnt;

   int checks = 0;
   int errors = 0;
   logic [79:0] exp_q[$];

   // clock
   always #5 clk = ~clk;

   pipe_stage_buf dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .bubble(bubble),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ctrl(out_ctrl), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
   );

   // Same stimulus, 2-bit bubble counter to exercise saturation.
   pipe_stage_buf #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .bubble(bubble),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .out_ctrl(s_out_ctrl), .occupancy(s_occupancy), .bubble_cnt(s_bubble_cnt)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beat(input logic [63:0] d, input logic [15:0] c);
      in_valid = 1'b1;
      in_data  = d;
      in_ctrl  = c;
      exp_q.push_back({c, d});
   endtask

   // monitor / scoreboard
   initial begin
      logic [79:0] e;
      forever begin
         @(negedge clk);
         if (rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat actual=%0h_%0h required=none", out_ctrl, out_data);
            end else begin
               e = exp_q.pop_front();
               if ({out_ctrl, out_data} !== e) begin
                  errors++;
                  $display("FAIL beat actual=%0h_%0h required=%0h_%0h",
                           out_ctrl, out_data, e[79:64], e[63:0]);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, NOP64);
      check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // streaming 8 beats with out_ready high
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive_beat(64'h1000_0000_0000_0000 + 64'(i * 17), 16'hA000 + 16'(i));
         tick();
         if (i == 0) begin
            check("stream_first_valid", 64'(out_valid), 64'd1);
            check("stream_first_data", out_data, 64'h1000_0000_0000_0000);
         end
         check("stream_occ", 64'(occupancy), 64'd1);
         check("stream_in_ready", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      tick();
      check("stream_drained_occ", 64'(occupancy), 64'd0);

      // backpressure: A, B held, then drained in order
      out_ready = 1'b0;
      drive_beat(64'h0000_0000_AAAA_0001, 16'h00A1);
      tick();
      drive_beat(64'h0000_0000_BBBB_0002, 16'h00B2);
      tick();
      in_valid = 1'b0;
      check("bp_occ2", 64'(occupancy), 64'd2);
      check("bp_in_ready0", 64'(in_ready), 64'd0);
      tick();
      check("bp_head_stable", out_data, 64'h0000_0000_AAAA_0001);
      check("bp_occ2_hold", 64'(occupancy), 64'd2);
      out_ready = 1'b1;
      tick();
      check("bp_after_a_occ", 64'(occupancy), 64'd1);
      check("bp_after_a_ready", 64'(in_ready), 64'd1);
      check("bp_after_a_head", out_data, 64'h0000_0000_BBBB_0002);
      tick();
      check("bp_empty", 64'(occupancy), 64'd0);

      // flush at occupancy 2 with a concurrent incoming beat C
      out_ready = 1'b0;
      drive_beat(64'h0000_0000_DDDD_0003, 16'h00D3);
      tick();
      drive_beat(64'h0000_0000_EEEE_0004, 16'h00E4);
      tick();
      check("fl_pre_occ", 64'(occupancy), 64'd2);
      in_valid = 1'b1;
      in_data  = 64'h0000_0000_CCCC_0005;
      in_ctrl  = 16'h00C5;
      flush    = 1'b1;
      exp_q.delete();
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl_out_valid", 64'(out_valid), 64'd0);
      check("fl_occ", 64'(occupancy), 64'd0);
      check("fl_out_ctrl", 64'(out_ctrl), 64'd0);
      check("fl_out_data", out_data, NOP64);
      check("fl_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      repeat (3) begin
         tick();
         check("fl_no_beat", 64'(out_valid), 64'd0);
      end

      // three bubbles on an empty buffer
      bubble = 1'b1;
      #1;
      check("bub_in_ready", 64'(in_ready), 64'd0);
      repeat (3) begin
         exp_q.push_back({16'h0000, NOP64});
         tick();
      end
      bubble = 1'b0;
      check("bub_cnt3", 64'(bubble_cnt), 64'd3);
      check("bub_sat_cnt3", 64'(s_bubble_cnt), 64'd3);
      tick();
      check("bub_drained", 64'(occupancy), 64'd0);

      // five more bubbles: 16-bit counter reaches 8, 2-bit counter stays at 3
      bubble = 1'b1;
      repeat (5) begin
         exp_q.push_back({16'h0000, NOP64});
         tick();
      end
      bubble = 1'b0;
      check("bub_cnt8", 64'(bubble_cnt), 64'd8);
      check("bub_sat_hold", 64'(s_bubble_cnt), 64'd3);
      tick();

      // bubble while a beat is held and stalled: no injection, no count
      out_ready = 1'b0;
      drive_beat(64'h0000_0000_FFFF_0006, 16'h00F6);
      tick();
      in_valid = 1'b0;
      bubble   = 1'b1;
      tick();
      check("bub_held_occ", 64'(occupancy), 64'd1);
      check("bub_held_data", out_data, 64'h0000_0000_FFFF_0006);
      check("bub_held_cnt", 64'(bubble_cnt), 64'd8);
      bubble    = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bub_held_drain", 64'(occupancy), 64'd0);

      // asynchronous reset mid-stream at occupancy 2
      out_ready = 1'b0;
      drive_beat(64'h0000_0000_1111_0007, 16'h0017);
      tick();
      drive_beat(64'h0000_0000_2222_0008, 16'h0028);
      tick();
      in_valid = 1'b0;
      check("ar_pre_occ", 64'(occupancy), 64'd2);
      #2;
      exp_q.delete();
      rst = 1'b0;
      #1;
      check("ar_out_valid", 64'(out_valid), 64'd0);
      check("ar_occ", 64'(occupancy), 64'd0);
      check("ar_out_data", out_data, NOP64);
      check("ar_out_ctrl", 64'(out_ctrl), 64'd0);
      check("ar_bubble_cnt", 64'(bubble_cnt), 64'd0);
      check("ar_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      repeat (3) begin
         tick();
         check("ar_no_beat", 64'(out_valid), 64'd0);
      end
      drive_beat(64'h0000_0000_3333_0009, 16'h0039);
      tick();
      in_valid = 1'b0;
      check("ar_new_valid", 64'(out_valid), 64'd1);
      check("ar_new_data", out_data, 64'h0000_0000_3333_0009);
      repeat (2) tick();

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
